// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transceiver.
package uart_pkg;

    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every CLOCK/(BAUD*OVERSAMPLE) clocks.
// No backpressure; free-running once out of reset.
module uart_baud_tick #(
    parameter int CLOCK      = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int DIV = CLOCK / (BAUD * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 1) begin : g_div_err
        $error("uart_baud_tick: CLOCK too low for BAUD*OVERSAMPLE");
    end

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst) cnt <= '0;
        else      cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART: TX drives the line the cycle after a tx_valid/tx_ready accept,
// RX pulses rx_valid at the stop-bit vote (~2 clk synchroniser delay plus half a bit).
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int CLOCK      = 50000000,
    parameter int BAUD       = 9600,
    parameter int DATA       = 8,
    parameter int PARITY     = 0,
    parameter int STOP       = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DATA-1:0] tx_data,
    input  logic            tx_valid,
    output logic            tx_ready,
    output logic            tx,
    input  logic            rx,
    output logic [DATA-1:0] rx_data,
    output logic            rx_valid,
    output logic            rx_parity_err,
    output logic            rx_frame_err
);
    localparam parity_t PMODE = (PARITY == 2) ? PAR_ODD : (PARITY == 1) ? PAR_EVEN : PAR_NONE;
    localparam int TW  = $clog2(STOP * OVERSAMPLE);
    localparam int RW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA);
    localparam int MID = OVERSAMPLE / 2;

    if (DATA < 5 || DATA > 9 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || STOP < 1 || STOP > 2)
    begin : g_param_err
        $error("uart_xcvr: illegal DATA/OVERSAMPLE/STOP");
    end

    logic tick;

    uart_baud_tick #(.CLOCK(CLOCK), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // ---------------- transmitter ----------------
    tx_state_t       tx_state;
    logic [TW-1:0]   tx_cnt;
    logic [BW-1:0]   tx_bits;
    logic [DATA-1:0] tx_sh;
    logic            tx_par;
    logic [TW-1:0]   tx_end;

    assign tx_ready = (tx_state == TX_IDLE) & rst;
    assign tx_end   = (tx_state == TX_STOP) ? TW'(STOP * OVERSAMPLE - 1) : TW'(OVERSAMPLE - 1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bits  <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            tx       <= 1'b1;
        end else if (tx_state == TX_IDLE) begin
            if (tx_valid) begin
                tx_sh    <= tx_data;
                tx_par   <= (^tx_data) ^ (PMODE == PAR_ODD);
                tx_cnt   <= '0;
                tx_bits  <= '0;
                tx       <= 1'b0;
                tx_state <= TX_START;
            end
        end else if (tick) begin
            if (tx_cnt != tx_end) begin
                tx_cnt <= tx_cnt + 1'b1;
            end else begin
                tx_cnt <= '0;
                case (tx_state)
                    TX_START: begin
                        tx       <= tx_sh[0];
                        tx_sh    <= tx_sh >> 1;
                        tx_state <= TX_DATA;
                    end
                    TX_DATA: begin
                        if (tx_bits == BW'(DATA - 1)) begin
                            tx       <= (PMODE == PAR_NONE) ? 1'b1 : tx_par;
                            tx_state <= (PMODE == PAR_NONE) ? TX_STOP : TX_PARITY;
                        end else begin
                            tx      <= tx_sh[0];
                            tx_sh   <= tx_sh >> 1;
                            tx_bits <= tx_bits + 1'b1;
                        end
                    end
                    TX_PARITY: begin
                        tx       <= 1'b1;
                        tx_state <= TX_STOP;
                    end
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    // ---------------- receiver ----------------
    rx_state_t       rx_state;
    logic            rx_m, rx_s;
    logic [RW-1:0]   rx_cnt;
    logic [BW-1:0]   rx_bits;
    logic [1:0]      smp;
    logic [DATA-1:0] rx_sh;
    logic            pe_r;
    logic            vote;

    // smp holds the samples from ticks MID-1 and MID when the counter reaches MID+1
    assign vote = maj3(smp[1], smp[0], rx_s);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_m          <= 1'b1;
            rx_s          <= 1'b1;
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_bits       <= '0;
            smp           <= 2'b11;
            rx_sh         <= '0;
            pe_r          <= 1'b0;
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_m     <= rx;
            rx_s     <= rx_m;
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: if (!rx_s) begin
                    rx_state <= RX_START;
                    rx_cnt   <= '0;
                end
                RX_BREAK: if (rx_s) rx_state <= RX_IDLE;
                default: if (tick) begin
                    rx_cnt <= (rx_cnt == RW'(OVERSAMPLE - 1)) ? '0 : rx_cnt + 1'b1;
                    smp    <= {smp[0], rx_s};
                    if (rx_cnt == RW'(MID + 1)) begin
                        case (rx_state)
                            RX_START: begin
                                rx_state <= vote ? RX_IDLE : RX_DATA;
                                rx_bits  <= '0;
                            end
                            RX_DATA: begin
                                rx_sh   <= {vote, rx_sh[DATA-1:1]};
                                rx_bits <= rx_bits + 1'b1;
                                if (rx_bits == BW'(DATA - 1))
                                    rx_state <= (PMODE == PAR_NONE) ? RX_STOP : RX_PARITY;
                            end
                            RX_PARITY: begin
                                pe_r     <= vote ^ (^rx_sh) ^ (PMODE == PAR_ODD);
                                rx_state <= RX_STOP;
                            end
                            default: begin
                                rx_data       <= rx_sh;
                                rx_parity_err <= (PMODE != PAR_NONE) & pe_r;
                                rx_frame_err  <= ~vote;
                                rx_valid      <= 1'b1;
                                rx_state      <= vote ? RX_IDLE : RX_BREAK;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
